// File: rtl/wb_broadcaster_if.sv
// Producer-side handshake and shared write-back bus of the write-back broadcaster.
// The producers and register file act as master; the broadcaster is the slave.
interface wb_broadcaster_if #(
   parameter int NUM_SRC = 4,
   parameter int DATA_W  = 32,
   parameter int REG_W   = 5,
   parameter int TAG_W   = 4
);
   logic [NUM_SRC-1:0]        src_valid;
   logic [NUM_SRC-1:0]        src_ready;
   logic [NUM_SRC*DATA_W-1:0] src_data;
   logic [NUM_SRC*REG_W-1:0]  src_reg;
   logic [NUM_SRC*TAG_W-1:0]  src_tag;
   logic                      wb_valid;
   logic [DATA_W-1:0]         wd;
   logic [REG_W-1:0]          wr;
   logic [TAG_W-1:0]          w_tag;

   modport master (
      output src_valid, src_data, src_reg, src_tag,
      input  src_ready, wb_valid, wd, wr, w_tag
   );

   modport slave (
      input  src_valid, src_data, src_reg, src_tag,
      output src_ready, wb_valid, wd, wr, w_tag
   );
endinterface

// File: rtl/wb_broadcaster.sv
// Collects functional-unit results into per-source hold slots and broadcasts one per cycle
// on the write-back bus, choosing among full slots round-robin.
module wb_broadcaster #(
   parameter int NUM_SRC     = 4,
   parameter int DATA_W      = 32,
   parameter int REG_W       = 5,
   parameter int TAG_W       = 4,
   parameter int TAG_INVALID = 0
) (
   input logic             clk,
   input logic             rst_tag,
   wb_broadcaster_if.slave bus
);
   localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam logic [TAG_W-1:0] TAG_IDLE = TAG_W'(TAG_INVALID);

   logic [NUM_SRC-1:0] full;
   logic [NUM_SRC-1:0] grant;
   logic [NUM_SRC-1:0] accept;
   logic [DATA_W-1:0]  slot_data [NUM_SRC];
   logic [REG_W-1:0]   slot_reg  [NUM_SRC];
   logic [TAG_W-1:0]   slot_tag  [NUM_SRC];
   logic [PTR_W-1:0]   ptr;
   logic [PTR_W-1:0]   grant_idx;
   logic               grant_any;

   // Scan full slots starting at the round-robin pointer; the first hit wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (!grant_any && full[(int'(ptr) + k) % NUM_SRC]) begin
            grant_any = 1'b1;
            grant_idx = PTR_W'((int'(ptr) + k) % NUM_SRC);
            grant[(int'(ptr) + k) % NUM_SRC] = 1'b1;
         end
      end
   end

   // A slot being drained this cycle can take a new result, so a granted source streams at full rate.
   assign bus.src_ready = rst_tag ? '0 : (~full | grant);
   assign accept        = bus.src_valid & bus.src_ready;

   always_ff @(posedge clk or posedge rst_tag) begin
      if (rst_tag) begin
         full         <= '0;
         ptr          <= '0;
         bus.wb_valid <= 1'b0;
         bus.wd       <= '0;
         bus.wr       <= '0;
         bus.w_tag    <= TAG_IDLE;
      end else begin
         if (grant_any) begin
            bus.wb_valid <= 1'b1;
            bus.wd       <= slot_data[grant_idx];
            bus.wr       <= slot_reg[grant_idx];
            bus.w_tag    <= slot_tag[grant_idx];
            ptr          <= (grant_idx == PTR_W'(NUM_SRC - 1)) ? '0 : grant_idx + PTR_W'(1);
         end else begin
            bus.wb_valid <= 1'b0;
            bus.wd       <= '0;
            bus.wr       <= '0;
            bus.w_tag    <= TAG_IDLE;
         end
         // Results carrying the invalid tag are consumed but never occupy a slot.
         for (int i = 0; i < NUM_SRC; i++) begin
            if (accept[i]) begin
               full[i] <= (bus.src_tag[i*TAG_W +: TAG_W] != TAG_IDLE);
            end else if (grant[i]) begin
               full[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SRC; i++) begin
         if (accept[i]) begin
            slot_data[i] <= bus.src_data[i*DATA_W +: DATA_W];
            slot_reg[i]  <= bus.src_reg[i*REG_W +: REG_W];
            slot_tag[i]  <= bus.src_tag[i*TAG_W +: TAG_W];
         end
      end
   end
endmodule
